// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the pipeline/memory side and mem_port_arbiter.
// The arbiter takes the slave view; the pipeline and memory model take the master view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_done;

    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_done;

    logic              stall_if;
    logic              stall_mem;

    logic              m_en;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;

    logic              proto_err;

    modport master (
        output if_req, if_addr, d_read, d_write, d_addr, d_wdata, m_rdata,
        input  if_rdata, if_done, d_rdata, d_done, stall_if, stall_mem,
               m_en, m_we, m_addr, m_wdata, proto_err
    );

    modport slave (
        input  if_req, if_addr, d_read, d_write, d_addr, d_wdata, m_rdata,
        output if_rdata, if_done, d_rdata, d_done, stall_if, stall_mem,
               m_en, m_we, m_addr, m_wdata, proto_err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between instruction fetch and the
// MEM stage; data wins by default, fetch wins after STARVE_MAX consecutive data grants.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);

    localparam logic [3:0] LAT_INIT   = 4'(MEM_LAT);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    typedef enum logic       {OWN_IF, OWN_D}           owner_t;

    state_t            state_q, state_d;
    owner_t            owner_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              we_q;
    logic [3:0]        cnt_q;
    logic [3:0]        starve_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              proto_err_q;

    logic d_pending;
    logic grant_if;
    logic grant_d;

    assign d_pending = bus.d_read | bus.d_write;

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        grant_if    = 1'b0;
        grant_d     = 1'b0;
        bus.m_en    = 1'b0;
        bus.m_we    = 1'b0;
        bus.m_addr  = '0;
        bus.m_wdata = '0;
        bus.if_done = 1'b0;
        bus.d_done  = 1'b0;
        case (state_q)
            IDLE: begin
                // Fetch only wins when data is idle or has used up its starvation budget.
                if (bus.if_req && (!d_pending || starve_q >= STARVE_LIM)) begin
                    grant_if = 1'b1;
                    state_d  = ISSUE;
                end else if (d_pending) begin
                    grant_d = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                bus.m_en    = 1'b1;
                bus.m_we    = we_q;
                bus.m_addr  = addr_q;
                bus.m_wdata = wdata_q;
                state_d     = WAIT;
            end
            WAIT: begin
                if (cnt_q == 4'd1) state_d = RESP;
            end
            RESP: begin
                bus.if_done = (owner_q == OWN_IF);
                bus.d_done  = (owner_q == OWN_D);
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: datapath registers are reset as well; rdata and proto_err are visible outputs that must read 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q     <= OWN_IF;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            cnt_q       <= '0;
            starve_q    <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            proto_err_q <= 1'b0;
        end else begin
            if (grant_if) begin
                owner_q <= OWN_IF;
                addr_q  <= bus.if_addr;
                wdata_q <= '0;
                we_q    <= 1'b0;
            end else if (grant_d) begin
                owner_q <= OWN_D;
                addr_q  <= bus.d_addr;
                wdata_q <= bus.d_wdata;
                we_q    <= bus.d_write;
                if (bus.d_read && bus.d_write) proto_err_q <= 1'b1;
            end

            if (grant_if)
                starve_q <= '0;
            else if (grant_d && bus.if_req)
                starve_q <= starve_q + 4'd1;
            else if (state_q == IDLE && !bus.if_req)
                starve_q <= '0;

            if (state_q == ISSUE)
                cnt_q <= LAT_INIT;
            else if (state_q == WAIT)
                cnt_q <= cnt_q - 4'd1;

            if (state_q == WAIT && cnt_q == 4'd1 && !we_q) begin
                if (owner_q == OWN_IF) if_rdata_q <= bus.m_rdata;
                else                   d_rdata_q  <= bus.m_rdata;
            end
        end
    end

    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.proto_err = proto_err_q;
    assign bus.stall_if  = bus.if_req & ~bus.if_done;
    assign bus.stall_mem = d_pending & ~bus.d_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: transaction-timing model checked every cycle,
// plus hand-computed expectations for fetch, collision, starvation, store, protocol error and reset.
module tb_mem_port_arbiter;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    bit   chk_en = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory: untouched words hold a recognisable pattern, word 0x10 holds an instruction.
    logic [31:0] mem_w [256];
    bit          written [256];
    logic [31:0] rd_pipe [MEM_LAT];
    bit          rd_vld [MEM_LAT];

    function automatic logic [31:0] mem_val(input logic [7:0] idx);
        if (written[idx]) return mem_w[idx];
        if (idx == 8'h10) return 32'h8C01_0004;
        return 32'hC0DE_0000 | 32'(idx);
    endfunction

    always @(posedge clk) begin
        if (bus.m_en && bus.m_we) begin
            mem_w[bus.m_addr[9:2]]   <= bus.m_wdata;
            written[bus.m_addr[9:2]] <= 1'b1;
        end
        rd_pipe[0] <= mem_val(bus.m_addr[9:2]);
        rd_vld[0]  <= bus.m_en && !bus.m_we;
        for (int i = 1; i < MEM_LAT; i++) begin
            rd_pipe[i] <= rd_pipe[i-1];
            rd_vld[i]  <= rd_vld[i-1];
        end
    end

    assign bus.m_rdata = rd_vld[MEM_LAT-1] ? rd_pipe[MEM_LAT-1] : (32'hBAD0_0000 ^ 32'(cyc));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Transaction-level model: a grant in cycle c means m_en at c+1, done at c+MEM_LAT+2,
    // and the next grant can be taken no earlier than c+MEM_LAT+3.
    int          issue_cyc = -1;
    int          done_cyc  = -1;
    int          free_cyc  = 0;
    bit          g_if;
    bit          g_we;
    logic [31:0] g_addr;
    logic [31:0] g_wdata;
    logic [31:0] g_data;
    logic [31:0] e_if_rdata = '0;
    logic [31:0] e_d_rdata  = '0;
    bit          e_proto = 1'b0;
    int          starve = 0;
    int          model_code = 0;
    int          dut_code = 0;
    int          men_at [logic [31:0]];
    bit          we_at  [logic [31:0]];

    always @(negedge clk) begin
        bit e_men, e_ifd, e_dd, dp, take_if;
        if (chk_en) begin
            if (rst) begin
                issue_cyc  = -1;
                done_cyc   = -1;
                free_cyc   = 0;
                e_if_rdata = '0;
                e_d_rdata  = '0;
                e_proto    = 1'b0;
                starve     = 0;
            end else if (cyc == done_cyc && !g_we) begin
                if (g_if) e_if_rdata = g_data;
                else      e_d_rdata  = g_data;
            end

            e_men = (cyc == issue_cyc);
            e_ifd = (cyc == done_cyc) && g_if;
            e_dd  = (cyc == done_cyc) && !g_if;
            check("m_en",      bus.m_en,      e_men);
            check("m_we",      bus.m_we,      e_men && g_we);
            check("m_addr",    bus.m_addr,    e_men ? g_addr : 32'h0);
            check("m_wdata",   bus.m_wdata,   e_men ? g_wdata : 32'h0);
            check("if_done",   bus.if_done,   e_ifd);
            check("d_done",    bus.d_done,    e_dd);
            check("if_rdata",  bus.if_rdata,  e_if_rdata);
            check("d_rdata",   bus.d_rdata,   e_d_rdata);
            check("stall_if",  bus.stall_if,  bus.if_req && !e_ifd);
            check("stall_mem", bus.stall_mem, (bus.d_read || bus.d_write) && !e_dd);
            check("proto_err", bus.proto_err, e_proto);

            if (bus.m_en) begin
                men_at[bus.m_addr] = cyc;
                we_at[bus.m_addr]  = bus.m_we;
            end
            if (bus.if_done) dut_code = dut_code * 16 + 1;
            if (bus.d_done)  dut_code = dut_code * 16 + 2;

            if (!rst && cyc >= free_cyc) begin
                dp = bus.d_read || bus.d_write;
                if (bus.if_req || dp) begin
                    take_if   = bus.if_req && (!dp || starve >= STARVE_MAX);
                    g_if      = take_if;
                    g_addr    = take_if ? bus.if_addr : bus.d_addr;
                    g_we      = !take_if && bus.d_write;
                    g_wdata   = take_if ? 32'h0 : bus.d_wdata;
                    g_data    = mem_val(g_addr[9:2]);
                    if (!take_if && bus.d_read && bus.d_write) e_proto = 1'b1;
                    starve    = take_if ? 0 : (bus.if_req ? starve + 1 : 0);
                    issue_cyc = cyc + 1;
                    done_cyc  = cyc + MEM_LAT + 2;
                    free_cyc  = cyc + MEM_LAT + 3;
                    model_code = model_code * 16 + (take_if ? 1 : 2);
                end else begin
                    starve = 0;
                end
            end
        end
    end

    task automatic fetch(input logic [31:0] a, output int t0, output int td);
        bus.if_req  = 1'b1;
        bus.if_addr = a;
        t0 = cyc;
        td = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.if_done) begin
                td = cyc;
                break;
            end
        end
        check("if_done_seen", td >= 0, 1);
        @(posedge clk); #1;
        bus.if_req  = 1'b0;
        bus.if_addr = '0;
    endtask

    task automatic dacc(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, output int t0, output int td);
        bus.d_read  = rd;
        bus.d_write = wr;
        bus.d_addr  = a;
        bus.d_wdata = wd;
        t0 = cyc;
        td = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.d_done) begin
                td = cyc;
                break;
            end
        end
        check("d_done_seen", td >= 0, 1);
        @(posedge clk); #1;
        bus.d_read  = 1'b0;
        bus.d_write = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ta, tb, tc, td, tx, ty;
        bus.if_req  = 1'b0;
        bus.if_addr = '0;
        bus.d_read  = 1'b0;
        bus.d_write = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;

        check("rst_m_en",      bus.m_en, 0);
        check("rst_if_rdata",  bus.if_rdata, 32'h0);
        check("rst_d_rdata",   bus.d_rdata, 32'h0);
        check("rst_proto_err", bus.proto_err, 0);
        repeat (2) @(posedge clk); #1;

        // Fetch only
        fetch(32'h40, ta, tb);
        check("t1_men_cyc",  men_at[32'h40] - ta, 1);
        check("t1_done_cyc", tb - ta, 4);
        check("t1_if_rdata", bus.if_rdata, 32'h8C01_0004);

        // Collision: data first, fetch right after
        fork
            fetch(32'h80, ta, tb);
            dacc(1'b1, 1'b0, 32'h100, 32'h0, tc, td);
        join
        check("t2_d_done_cyc",  td - tc, 4);
        check("t2_if_men_cyc",  men_at[32'h80] - ta, 6);
        check("t2_if_done_cyc", tb - ta, 9);
        check("t2_d_rdata",     bus.d_rdata, 32'hC0DE_0040);
        check("t2_if_rdata",    bus.if_rdata, 32'hC0DE_0020);

        // Starvation: D, D, I, D  (encoded D=2, I=1)
        dut_code   = 0;
        model_code = 0;
        fork
            fetch(32'h48, ta, tb);
            for (int i = 0; i < 3; i++) dacc(1'b1, 1'b0, 32'h104 + 32'(4 * i), 32'h0, tx, ty);
        join
        check("t3_order_dut",   dut_code, 32'h2212);
        check("t3_order_model", model_code, 32'h2212);
        check("t3_if_done_cyc", tb - ta, 14);
        check("t3_d_rdata",     bus.d_rdata, 32'hC0DE_0043);
        check("t3_if_rdata",    bus.if_rdata, 32'hC0DE_0012);

        // Store, then read it back
        dacc(1'b0, 1'b1, 32'h20, 32'hDEAD_BEEF, tc, td);
        check("t4_we_with_en",  we_at[32'h20], 1);
        check("t4_done_cyc",    td - tc, 4);
        check("t4_d_rdata_hold", bus.d_rdata, 32'hC0DE_0043);
        dacc(1'b1, 1'b0, 32'h20, 32'h0, tc, td);
        check("t4_readback",    bus.d_rdata, 32'hDEAD_BEEF);

        // Read and write together: treated as a write, sticky error
        dacc(1'b1, 1'b1, 32'h30, 32'h1234_5678, tc, td);
        check("t6_proto_err",   bus.proto_err, 1);
        check("t6_is_write",    we_at[32'h30], 1);
        check("t6_d_rdata_hold", bus.d_rdata, 32'hDEAD_BEEF);
        fetch(32'h44, ta, tb);
        check("t6_proto_sticky", bus.proto_err, 1);
        dacc(1'b1, 1'b0, 32'h30, 32'h0, tc, td);
        check("t6_readback",    bus.d_rdata, 32'h1234_5678);

        // Reset while the access is in WAIT
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h4C;
        ta = cyc;
        repeat (2) @(posedge clk); #1;
        dut_code = 0;
        rst = 1'b1;
        bus.if_req = 1'b0;
        #1;
        check("t5_m_en",      bus.m_en, 0);
        check("t5_if_done",   bus.if_done, 0);
        check("t5_if_rdata",  bus.if_rdata, 32'h0);
        check("t5_d_rdata",   bus.d_rdata, 32'h0);
        check("t5_proto_err", bus.proto_err, 0);
        repeat (3) @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk); #1;
        check("t5_no_done", dut_code, 0);
        fetch(32'h4C, ta, tb);
        check("t5_refetch_cyc",   tb - ta, 4);
        check("t5_refetch_rdata", bus.if_rdata, 32'hC0DE_0013);

        repeat (2) @(posedge clk); #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
